// File: rtl/prewish_pkg.sv
// prewish_pkg: shared constants for the prewish mask sequencer.
//   MASK_W       - blink mask width
//   seq_state_e  - sequencer FSM states (IDLE, SEND)
//   default_mask - preload contents of the mask table, by entry index
package prewish_pkg;

  localparam int unsigned MASK_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } seq_state_e;

  function automatic logic [MASK_W-1:0] default_mask(input int unsigned idx);
    logic [MASK_W-1:0] m;
    case (idx % 8)
      0:       m = 8'b10101000;
      1:       m = 8'b11001010;
      2:       m = 8'b11110000;
      3:       m = 8'b10000000;
      4:       m = 8'b11111110;
      5:       m = 8'b10101010;
      6:       m = 8'b11001100;
      default: m = 8'b11100000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/prewish_prescaler.sv
// prewish_prescaler: free-running counter with enable/clear and a one-cycle tick.
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   en_i   - count enable; when low the counter is cleared and held at 0
//   tick_o - high for one cycle while the counter is all-ones and enabled
module prewish_prescaler #(
  parameter int unsigned CLK_BITS = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  logic [CLK_BITS-1:0] cnt_q, cnt_d;

  // The all-ones value wraps naturally to 0 on the following increment.
  always_comb begin
    cnt_d  = en_i ? cnt_q + 1'b1 : '0;
    tick_o = en_i && (cnt_q == '1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/prewish_mask_sequencer.sv
// prewish_mask_sequencer: periodically presents the next mask from an
// 8-entry rewritable table to the blinky stage over a strobe/ack handshake.
//   CLK_I, RST_I - clock, asynchronous active-high reset
//   EN_I         - sequencing enable (gates the prescaler only)
//   WE_I/ADR_I/DAT_I - table write port, accepted in any state
//   STB_O/DAT_O  - new-mask strobe and mask, held until ACK_I
//   ACK_I        - blinky accepted the mask
//   IDX_O        - index of the last acknowledged mask
//   OVR_O        - sticky: a tick arrived while a mask was unacknowledged
module prewish_mask_sequencer
  import prewish_pkg::*;
#(
  parameter int unsigned NEWMASK_CLK_BITS = 26,
  parameter int unsigned NUM_MASKS_LOG2   = 3
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic                      EN_I,
  input  logic                      WE_I,
  input  logic [NUM_MASKS_LOG2-1:0] ADR_I,
  input  logic [MASK_W-1:0]         DAT_I,
  output logic                      STB_O,
  output logic [MASK_W-1:0]         DAT_O,
  input  logic                      ACK_I,
  output logic [NUM_MASKS_LOG2-1:0] IDX_O,
  output logic                      OVR_O
);

  localparam int unsigned DEPTH = 1 << NUM_MASKS_LOG2;

  logic tick;

  prewish_prescaler #(
    .CLK_BITS(NEWMASK_CLK_BITS)
  ) u_prescaler (
    .clk_i (CLK_I),
    .rst_i (RST_I),
    .en_i  (EN_I),
    .tick_o(tick)
  );

  logic [MASK_W-1:0] tab_q [DEPTH];

  // The FSM reads tab_q before this edge's write lands, so a same-cycle
  // write to the entry being fetched delivers the old contents.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int unsigned i = 0; i < DEPTH; i++) tab_q[i] <= default_mask(i);
    end else if (WE_I) begin
      tab_q[ADR_I] <= DAT_I;
    end
  end

  seq_state_e                state_q, state_d;
  logic                      stb_q, stb_d;
  logic [MASK_W-1:0]         dat_q, dat_d;
  logic [NUM_MASKS_LOG2-1:0] idx_q, idx_d;
  logic [NUM_MASKS_LOG2-1:0] ptr_q, ptr_d;
  logic                      ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    dat_d   = dat_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          dat_d   = tab_q[ptr_q];
          stb_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // A tick here is dropped; it only flags the overrun, even when the
        // ack completes in the same cycle.
        if (tick) ovr_d = 1'b1;
        if (ACK_I) begin
          stb_d   = 1'b0;
          idx_d   = ptr_q;
          ptr_d   = ptr_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      dat_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign STB_O = stb_q;
  assign DAT_O = dat_q;
  assign IDX_O = idx_q;
  assign OVR_O = ovr_q;

endmodule

// File: tb/tb_prewish_mask_sequencer.sv
module tb_prewish_mask_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, we = 1'b0, ack = 1'b0;
  logic [2:0] adr = '0;
  logic [7:0] wdat = '0;
  logic       stb, ovr;
  logic [7:0] dat;
  logic [2:0] idx;

  always #5 clk = ~clk;

  prewish_mask_sequencer #(
    .NEWMASK_CLK_BITS(4),
    .NUM_MASKS_LOG2  (3)
  ) dut (
    .CLK_I(clk), .RST_I(rst), .EN_I(en), .WE_I(we), .ADR_I(adr), .DAT_I(wdat),
    .STB_O(stb), .DAT_O(dat), .ACK_I(ack), .IDX_O(idx), .OVR_O(ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: every 16th consecutive enabled cycle is a
  // tick; a tick while a mask is outstanding is an overrun, otherwise the
  // next table entry is offered until acknowledged.
  logic [7:0] defaults [8] = '{8'hA8, 8'hCA, 8'hF0, 8'h80, 8'hFE, 8'hAA, 8'hCC, 8'hE0};
  logic [7:0] m_tab [8];
  int         run_len;
  bit         busy, m_ovr;
  logic [7:0] m_dat;
  int         m_idx, m_ptr;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tab[i] = defaults[i];
    run_len = 0; busy = 0; m_ovr = 0; m_dat = 8'h00; m_idx = 0; m_ptr = 0;
  endtask

  task automatic model_edge();
    bit tk;
    tk = 0;
    if (en) begin
      tk = ((run_len % 16) == 15);
      run_len = run_len + 1;
    end else begin
      run_len = 0;
    end
    if (busy) begin
      if (tk) m_ovr = 1;
      if (ack) begin
        busy = 0;
        m_idx = m_ptr;
        m_ptr = (m_ptr + 1) % 8;
      end
    end else if (tk) begin
      m_dat = m_tab[m_ptr];
      busy = 1;
    end
    if (we) m_tab[adr] = wdat;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_stb", {7'd0, stb}, {7'd0, busy});
    chk("model_dat", dat, m_dat);
    chk("model_idx", {5'd0, idx}, m_idx[7:0]);
    chk("model_ovr", {7'd0, ovr}, {7'd0, m_ovr});
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ack = 1'b0; we = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    int unsigned cycles;
    bit          en, ack, we;
    logic [2:0]  adr;
    logic [7:0]  wdat;
    bit          stb;
    logic [7:0]  dat;
    logic [2:0]  idx;
    bit          ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input int unsigned c, input bit e, input bit a, input bit w,
                     input logic [2:0] ad, input logic [7:0] wd,
                     input bit s, input logic [7:0] d, input logic [2:0] ix, input bit o);
    vec_t v;
    v.rst = r; v.cycles = c; v.en = e; v.ack = a; v.we = w; v.adr = ad; v.wdat = wd;
    v.stb = s; v.dat = d; v.idx = ix; v.ovr = o;
    vecs.push_back(v);
  endtask

  initial begin
    // Free run with ack tied high: ticks at 16/32/48, then wrap on tick 9.
    add(1, 15, 1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 1, 8'hA8, 0, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 0, 8'hA8, 0, 0);
    add(0, 14, 1, 1, 0, 0, 8'h00, 0, 8'hA8, 0, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 1, 8'hCA, 0, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 0, 8'hCA, 1, 0);
    add(0, 15, 1, 1, 0, 0, 8'h00, 1, 8'hF0, 1, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 0, 8'hF0, 2, 0);
    add(0, 95, 1, 1, 0, 0, 8'h00, 1, 8'hA8, 7, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 0, 8'hA8, 0, 0);
    // Ack held low for 20 cycles: strobe holds, second tick is an overrun.
    add(1, 16, 1, 0, 0, 0, 8'h00, 1, 8'hA8, 0, 0);
    add(0, 15, 1, 0, 0, 0, 8'h00, 1, 8'hA8, 0, 0);
    add(0,  1, 1, 0, 0, 0, 8'h00, 1, 8'hA8, 0, 1);
    add(0,  4, 1, 0, 0, 0, 8'h00, 1, 8'hA8, 0, 1);
    add(0,  1, 1, 1, 0, 0, 8'h00, 0, 8'hA8, 0, 1);
    add(0, 11, 1, 1, 0, 0, 8'h00, 1, 8'hCA, 0, 1);
    add(0,  1, 1, 1, 0, 0, 8'h00, 0, 8'hCA, 1, 1);
    // Table write before the second tick.
    add(1, 16, 1, 1, 1, 1, 8'h5A, 1, 8'hA8, 0, 0);
    add(0, 16, 1, 1, 0, 0, 8'h00, 1, 8'h5A, 0, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 0, 8'h5A, 1, 0);
    // Write coinciding with the tick that reads the same entry.
    add(1, 16, 1, 1, 0, 0, 8'h00, 1, 8'hA8, 0, 0);
    add(0, 15, 1, 1, 0, 0, 8'h00, 0, 8'hA8, 0, 0);
    add(0,  1, 1, 1, 1, 1, 8'h3C, 1, 8'hCA, 0, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 0, 8'hCA, 1, 0);
    add(0,127, 1, 1, 0, 0, 8'h00, 1, 8'h3C, 0, 0);
    // Enable dropped mid-transfer: transfer still completes, prescaler restarts.
    add(1, 16, 1, 0, 0, 0, 8'h00, 1, 8'hA8, 0, 0);
    add(0,  5, 0, 0, 0, 0, 8'h00, 1, 8'hA8, 0, 0);
    add(0,  1, 0, 1, 0, 0, 8'h00, 0, 8'hA8, 0, 0);
    add(0, 15, 1, 1, 0, 0, 8'h00, 0, 8'hA8, 0, 0);
    add(0,  1, 1, 1, 0, 0, 8'h00, 1, 8'hCA, 0, 0);

    model_reset();
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].rst) begin
        do_reset();
        chk("reset_stb", {7'd0, stb}, 8'h00);
        chk("reset_dat", dat, 8'h00);
        chk("reset_idx", {5'd0, idx}, 8'h00);
        chk("reset_ovr", {7'd0, ovr}, 8'h00);
      end
      for (int unsigned c = 0; c < vecs[v].cycles; c++) begin
        en   = vecs[v].en;
        ack  = vecs[v].ack;
        we   = (c == 0) ? vecs[v].we : 1'b0;
        adr  = vecs[v].adr;
        wdat = vecs[v].wdat;
        step();
      end
      we = 1'b0;
      chk($sformatf("vec%0d_stb", v), {7'd0, stb}, {7'd0, vecs[v].stb});
      chk($sformatf("vec%0d_dat", v), dat, vecs[v].dat);
      chk($sformatf("vec%0d_idx", v), {5'd0, idx}, {5'd0, vecs[v].idx});
      chk($sformatf("vec%0d_ovr", v), {7'd0, ovr}, {7'd0, vecs[v].ovr});
    end

    // Asynchronous reset pulse between edges while a mask is outstanding.
    do_reset();
    en = 1'b1; ack = 1'b0; wdat = 8'h77; adr = 3'd0;
    we = 1'b1;
    step();
    we = 1'b0;
    for (int i = 0; i < 31; i++) step();
    chk("pre_async_stb", {7'd0, stb}, 8'h01);
    chk("pre_async_ovr", {7'd0, ovr}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("async_stb_drop", {7'd0, stb}, 8'h00);
    chk("async_ovr_clr", {7'd0, ovr}, 8'h00);
    chk("async_dat_clr", dat, 8'h00);
    model_reset();
    #1 rst = 1'b0;
    ack = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("post_async_quiet", {7'd0, stb}, 8'h00);
    step();
    chk("post_async_stb", {7'd0, stb}, 8'h01);
    chk("post_async_dat", dat, 8'hA8);
    chk("post_async_ovr", {7'd0, ovr}, 8'h00);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 15) != 0);
      ack  = ($urandom_range(0, 2) == 0);
      we   = ($urandom_range(0, 7) == 0);
      adr  = 3'($urandom);
      wdat = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
